// File: rtl/cardinal_run_monitor.sv
// Run-control and completion monitor for an N-node Cardinal CMP: counts run cycles,
// detects per-node halt, runs a flush countdown, tracks memory traffic and a timeout.
//
// state | meaning
// IDLE  | waiting for start after reset
// RUN   | counting cycles, watching halt instructions and memory traffic
// FLUSH | all nodes halted, draining the pipeline for FLUSH_CYCLES edges
// DONE  | results held until the next start
module cardinal_run_monitor #(
   parameter int                NUM_NODES    = 4,
   parameter int                INST_W       = 32,
   parameter int                CNT_W        = 32,
   parameter logic [INST_W-1:0] HALT_INST    = '0,
   parameter int                HALT_HOLD    = 1,
   parameter int                FLUSH_CYCLES = 5,
   parameter int                TIMEOUT      = 12500,
   parameter int                ALL_SIMULT   = 0
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic [NUM_NODES*INST_W-1:0]   inst_in,
   input  logic [NUM_NODES-1:0]          mem_en,
   input  logic [NUM_NODES-1:0]          mem_wr_en,
   output logic                          busy,
   output logic                          done,
   output logic                          timed_out,
   output logic [NUM_NODES-1:0]          node_halted,
   output logic [CNT_W-1:0]              cycle_count,
   output logic [NUM_NODES*CNT_W-1:0]    node_halt_cyc,
   output logic [NUM_NODES*CNT_W-1:0]    mem_rd_cnt,
   output logic [NUM_NODES*CNT_W-1:0]    mem_wr_cnt
);

   localparam int               HW         = (HALT_HOLD < 1) ? 1 : $clog2(HALT_HOLD + 1);
   localparam logic [HW-1:0]    HOLD_MAX   = HW'(HALT_HOLD);
   localparam int               FW         = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [FW-1:0]    FLUSH_LOAD = (FLUSH_CYCLES > 0) ? FW'(FLUSH_CYCLES - 1) : '0;
   localparam logic [CNT_W-1:0] CNT_MAX    = '1;
   localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

   state_t               state;
   logic [FW-1:0]        flush_cnt;
   logic [HW-1:0]        hold_cnt [NUM_NODES];
   logic [HW-1:0]        hold_nxt [NUM_NODES];
   logic [NUM_NODES-1:0] met;
   logic [NUM_NODES-1:0] halted_nxt;
   logic [NUM_NODES-1:0] latch_cyc;
   logic                 tmo_hit;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_W'(1);
   endfunction

   always_comb begin
      halted_nxt = '0;
      met        = '0;
      latch_cyc  = '0;
      for (int i = 0; i < NUM_NODES; i++) begin
         hold_nxt[i] = '0;
         if (inst_in[i*INST_W +: INST_W] == HALT_INST)
            hold_nxt[i] = (hold_cnt[i] == HOLD_MAX) ? hold_cnt[i] : hold_cnt[i] + HW'(1);
         met[i]        = (hold_nxt[i] == HOLD_MAX);
         halted_nxt[i] = (ALL_SIMULT != 0) ? met[i] : (node_halted[i] | met[i]);
         latch_cyc[i]  = met[i] & ~node_halted[i];
      end
   end

   assign tmo_hit = (TIMEOUT != 0) && (cycle_count == TMO_LAST);
   assign busy    = (state == S_RUN) || (state == S_FLUSH);
   assign done    = (state == S_DONE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= S_IDLE;
         flush_cnt     <= '0;
         timed_out     <= 1'b0;
         node_halted   <= '0;
         cycle_count   <= '0;
         node_halt_cyc <= '0;
         mem_rd_cnt    <= '0;
         mem_wr_cnt    <= '0;
         for (int i = 0; i < NUM_NODES; i++) hold_cnt[i] <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state         <= S_RUN;
                  flush_cnt     <= '0;
                  timed_out     <= 1'b0;
                  node_halted   <= '0;
                  cycle_count   <= '0;
                  node_halt_cyc <= '0;
                  mem_rd_cnt    <= '0;
                  mem_wr_cnt    <= '0;
                  for (int i = 0; i < NUM_NODES; i++) hold_cnt[i] <= '0;
               end
            end
            S_RUN: begin
               cycle_count <= sat_inc(cycle_count);
               node_halted <= halted_nxt;
               for (int i = 0; i < NUM_NODES; i++) begin
                  hold_cnt[i] <= hold_nxt[i];
                  if (latch_cyc[i]) node_halt_cyc[i*CNT_W +: CNT_W] <= cycle_count;
                  if (mem_en[i] && !mem_wr_en[i])
                     mem_rd_cnt[i*CNT_W +: CNT_W] <= sat_inc(mem_rd_cnt[i*CNT_W +: CNT_W]);
                  if (mem_en[i] && mem_wr_en[i])
                     mem_wr_cnt[i*CNT_W +: CNT_W] <= sat_inc(mem_wr_cnt[i*CNT_W +: CNT_W]);
               end
               // timeout wins over a simultaneous all-halted condition
               if (tmo_hit) begin
                  state     <= S_DONE;
                  timed_out <= 1'b1;
               end else if (&halted_nxt) begin
                  if (FLUSH_CYCLES > 0) begin
                     state     <= S_FLUSH;
                     flush_cnt <= FLUSH_LOAD;
                  end else begin
                     state <= S_DONE;
                  end
               end
            end
            S_FLUSH: begin
               if (flush_cnt == '0) state <= S_DONE;
               else                 flush_cnt <= flush_cnt - FW'(1);
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cardinal_run_monitor.sv
// Bench for cardinal_run_monitor: four parameter variants share one stimulus stream,
// directed scenarios use constant expectations, the random phase uses a cycle model.
module tb_cardinal_run_monitor;

   logic         clk;
   logic         reset;
   logic         start;
   logic [127:0] inst_in;
   logic [3:0]   mem_en;
   logic [3:0]   mem_wr_en;

   logic         busy_w   [4];
   logic         done_w   [4];
   logic         to_w     [4];
   logic [3:0]   halted_w [4];
   logic [31:0]  cyc_w    [4];
   logic [127:0] hcyc_w   [4];
   logic [127:0] rd_w     [4];
   logic [127:0] wr_w     [4];

   int vectors;
   int miscompares;

   // variant 0: defaults, 1: ALL_SIMULT=1, 2: HALT_HOLD=3, 3: TIMEOUT=20
   for (genvar g = 0; g < 4; g++) begin : g_dut
      cardinal_run_monitor #(
         .NUM_NODES(4), .INST_W(32), .CNT_W(32), .HALT_INST(32'h0),
         .HALT_HOLD((g == 2) ? 3 : 1), .FLUSH_CYCLES(5),
         .TIMEOUT((g == 3) ? 20 : 12500), .ALL_SIMULT((g == 1) ? 1 : 0)
      ) u_dut (
         .clk(clk), .reset(reset), .start(start), .inst_in(inst_in),
         .mem_en(mem_en), .mem_wr_en(mem_wr_en),
         .busy(busy_w[g]), .done(done_w[g]), .timed_out(to_w[g]),
         .node_halted(halted_w[g]), .cycle_count(cyc_w[g]),
         .node_halt_cyc(hcyc_w[g]), .mem_rd_cnt(rd_w[g]), .mem_wr_cnt(wr_w[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int p_hold(int k); return (k == 2) ? 3 : 1; endfunction
   function automatic int p_tmo(int k);  return (k == 3) ? 20 : 12500; endfunction
   function automatic bit p_sim(int k);  return (k == 1); endfunction

   // reference model: phase 0 idle, 1 run, 2 flush, 3 done
   int          m_phase [4];
   int unsigned m_cyc   [4];
   bit          m_to    [4];
   bit [3:0]    m_halt  [4];
   int          m_fl    [4];
   int unsigned m_hcyc  [4][4];
   int unsigned m_rd    [4][4];
   int unsigned m_wr    [4][4];
   int          m_run   [4][4];
   bit [3:0]    m_nh;
   bit          m_met;

   always @(posedge clk or posedge reset) begin
      for (int k = 0; k < 4; k++) begin
         if (reset || ((m_phase[k] == 0 || m_phase[k] == 3) && start)) begin
            m_phase[k] = reset ? 0 : 1;
            m_cyc[k] = 0; m_to[k] = 0; m_halt[k] = '0; m_fl[k] = 0;
            for (int n = 0; n < 4; n++) begin
               m_hcyc[k][n] = 0; m_rd[k][n] = 0; m_wr[k][n] = 0; m_run[k][n] = 0;
            end
         end else if (m_phase[k] == 1) begin
            m_nh = m_halt[k];
            for (int n = 0; n < 4; n++) begin
               m_run[k][n] = (inst_in[n*32 +: 32] == 32'h0) ? m_run[k][n] + 1 : 0;
               m_met = (m_run[k][n] >= p_hold(k));
               if (m_met && !m_halt[k][n]) m_hcyc[k][n] = m_cyc[k];
               m_nh[n] = p_sim(k) ? m_met : (m_nh[n] | m_met);
               if (mem_en[n] && mem_wr_en[n])  m_wr[k][n]++;
               if (mem_en[n] && !mem_wr_en[n]) m_rd[k][n]++;
            end
            m_halt[k] = m_nh;
            if (m_cyc[k] == p_tmo(k) - 1) begin
               m_phase[k] = 3; m_to[k] = 1;
            end else if (m_nh == 4'hF) begin
               m_phase[k] = 2; m_fl[k] = 5;
            end
            m_cyc[k]++;
         end else if (m_phase[k] == 2) begin
            m_fl[k]--;
            if (m_fl[k] == 0) m_phase[k] = 3;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_inst(input int n, input logic [31:0] v);
      inst_in[n*32 +: 32] = v;
   endtask

   function automatic logic [31:0] nz();
      return $urandom | 32'h1;
   endfunction

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // drive halts on every node until no variant is busy
   task automatic settle();
      int n;
      n = 0;
      inst_in = '0; mem_en = '0; mem_wr_en = '0;
      while ((busy_w[0] || busy_w[1] || busy_w[2] || busy_w[3]) && n < 100) begin
         tick();
         n++;
      end
      vectors++;
      if (n >= 100) begin
         miscompares++;
         $display("FAIL settle_timeout: still busy after %0d cycles, required idle", n);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; inst_in = '1; mem_en = '0; mem_wr_en = '0;
      #2;
      for (int k = 0; k < 4; k++) begin
         vectors++;
         if ({busy_w[k], done_w[k], to_w[k], halted_w[k], cyc_w[k], hcyc_w[k], rd_w[k], wr_w[k]} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs[%0d]: got busy=%b done=%b cyc=%0h, required all zero", k, busy_w[k], done_w[k], cyc_w[k]);
         end
      end
      tick();
      reset = 1'b0;
      tick(); tick();
      vectors++;
      if (busy_w[0] !== 1'b0 || done_w[0] !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_idle: got busy=%b done=%b, required 0 0", busy_w[0], done_w[0]);
      end
   endtask

   task automatic test_all_halt();
      settle();
      for (int n = 0; n < 4; n++) set_inst(n, nz());
      do_start();
      for (int c = 0; c < 10; c++) tick();
      inst_in = '0;
      tick();
      vectors++;
      if (halted_w[0] !== 4'hF || cyc_w[0] !== 32'd11 || busy_w[0] !== 1'b1) begin
         miscompares++;
         $display("FAIL all_halt_flags: got halted=%h cyc=%0d busy=%b, required F 11 1", halted_w[0], cyc_w[0], busy_w[0]);
      end
      for (int n = 0; n < 4; n++) begin
         vectors++;
         if (hcyc_w[0][n*32 +: 32] !== 32'd10) begin
            miscompares++;
            $display("FAIL all_halt_cyc[%0d]: got %0d required 10", n, hcyc_w[0][n*32 +: 32]);
         end
      end
      for (int c = 0; c < 4; c++) tick();
      vectors++;
      if (done_w[0] !== 1'b0) begin
         miscompares++;
         $display("FAIL flush_early: got done=%b after 4 flush edges, required 0", done_w[0]);
      end
      tick();
      vectors++;
      if (done_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || cyc_w[0] !== 32'd11) begin
         miscompares++;
         $display("FAIL flush_done: got done=%b busy=%b cyc=%0d, required 1 0 11", done_w[0], busy_w[0], cyc_w[0]);
      end
   endtask

   // variants 0 (sticky) and 1 (simultaneous) see the same stimulus
   task automatic test_sticky_and_simult();
      settle();
      for (int n = 0; n < 4; n++) set_inst(n, nz());
      do_start();
      for (int c = 0; c < 16; c++) begin
         for (int n = 0; n < 4; n++)
            set_inst(n, (c >= 3*(n+1) && !(n == 0 && c >= 7 && c <= 14)) ? 32'h0 : nz());
         tick();
         if (c == 12 || c == 14) begin
            vectors++;
            if (halted_w[0] !== 4'hF || busy_w[0] !== 1'b1 || cyc_w[0] !== 32'd13) begin
               miscompares++;
               $display("FAIL sticky_hold c=%0d: got halted=%h busy=%b cyc=%0d, required F 1 13", c, halted_w[0], busy_w[0], cyc_w[0]);
            end
            vectors++;
            if (halted_w[1] !== 4'b1110 || busy_w[1] !== 1'b1 || cyc_w[1] !== 32'(c + 1)) begin
               miscompares++;
               $display("FAIL simult_wait c=%0d: got halted=%h busy=%b cyc=%0d, required e 1 %0d", c, halted_w[1], busy_w[1], cyc_w[1], c + 1);
            end
         end
      end
      vectors++;
      if (halted_w[1] !== 4'hF || cyc_w[1] !== 32'd16) begin
         miscompares++;
         $display("FAIL simult_exit: got halted=%h cyc=%0d, required F 16", halted_w[1], cyc_w[1]);
      end
      for (int c = 0; c < 5; c++) tick();
      vectors++;
      if (done_w[0] !== 1'b1 || done_w[1] !== 1'b1) begin
         miscompares++;
         $display("FAIL sticky_simult_done: got done0=%b done1=%b, required 1 1", done_w[0], done_w[1]);
      end
      vectors++;
      if (hcyc_w[0] !== {32'd12, 32'd9, 32'd6, 32'd3}) begin
         miscompares++;
         $display("FAIL sticky_halt_cyc: got %h required 0000000c000000090000000600000003", hcyc_w[0]);
      end
      vectors++;
      if (hcyc_w[1] !== {32'd12, 32'd9, 32'd6, 32'd15}) begin
         miscompares++;
         $display("FAIL simult_halt_cyc: got %h required 0000000c00000009000000060000000f", hcyc_w[1]);
      end
   endtask

   task automatic test_halt_hold();
      settle();
      for (int n = 0; n < 4; n++) set_inst(n, nz());
      do_start();
      for (int c = 0; c < 9; c++) begin
         set_inst(1, (c == 2 || c == 3 || c >= 6) ? 32'h0 : nz());
         tick();
         if (c == 3 || c == 7) begin
            vectors++;
            if (halted_w[2][1] !== 1'b0) begin
               miscompares++;
               $display("FAIL hold_short c=%0d: got halted[1]=%b required 0", c, halted_w[2][1]);
            end
         end
      end
      vectors++;
      if (halted_w[2] !== 4'b0010 || hcyc_w[2][63:32] !== 32'd8) begin
         miscompares++;
         $display("FAIL hold_met: got halted=%h cyc1=%0d, required 2 8", halted_w[2], hcyc_w[2][63:32]);
      end
   endtask

   task automatic test_timeout();
      int n;
      settle();
      for (int k = 0; k < 4; k++) set_inst(k, 32'h0);
      set_inst(2, nz());
      do_start();
      n = 0;
      while (done_w[3] !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      vectors++;
      if (n != 20 || cyc_w[3] !== 32'd20 || to_w[3] !== 1'b1 || halted_w[3] !== 4'b1011) begin
         miscompares++;
         $display("FAIL timeout: got edges=%0d cyc=%0d to=%b halted=%h, required 20 20 1 b", n, cyc_w[3], to_w[3], halted_w[3]);
      end
      vectors++;
      if (busy_w[0] !== 1'b1 || to_w[0] !== 1'b0) begin
         miscompares++;
         $display("FAIL no_timeout_v0: got busy=%b to=%b, required 1 0", busy_w[0], to_w[0]);
      end
   endtask

   task automatic test_restart_clears();
      settle();
      vectors++;
      if (done_w[3] !== 1'b1 || to_w[3] !== 1'b1 || cyc_w[0] === 32'd0) begin
         miscompares++;
         $display("FAIL restart_pre: got done3=%b to3=%b cyc0=%0d, required 1 1 nonzero", done_w[3], to_w[3], cyc_w[0]);
      end
      do_start();
      for (int k = 0; k < 4; k++) begin
         vectors++;
         if (busy_w[k] !== 1'b1 || to_w[k] !== 1'b0 || halted_w[k] !== 4'h0 || cyc_w[k] !== 32'd0 ||
             hcyc_w[k] !== '0 || rd_w[k] !== '0 || wr_w[k] !== '0) begin
            miscompares++;
            $display("FAIL restart_clear[%0d]: got busy=%b to=%b halted=%h cyc=%0d, required 1 0 0 0", k, busy_w[k], to_w[k], halted_w[k], cyc_w[k]);
         end
      end
   endtask

   task automatic test_mem_counts_and_async_reset();
      logic [1:0] pat [7];
      pat = '{2'b10, 2'b01, 2'b11, 2'b10, 2'b00, 2'b11, 2'b10};
      settle();
      for (int n = 0; n < 4; n++) set_inst(n, nz());
      do_start();
      for (int c = 0; c < 7; c++) begin
         mem_en[0] = pat[c][1]; mem_wr_en[0] = pat[c][0];
         tick();
      end
      mem_en = '0; mem_wr_en = '0;
      vectors++;
      if (rd_w[0][31:0] !== 32'd3 || wr_w[0][31:0] !== 32'd2 || rd_w[0][127:32] !== '0 || wr_w[0][127:32] !== '0) begin
         miscompares++;
         $display("FAIL mem_counts: got rd0=%0d wr0=%0d, required 3 2", rd_w[0][31:0], wr_w[0][31:0]);
      end
      vectors++;
      if (busy_w[0] !== 1'b1 || cyc_w[0] !== 32'd7) begin
         miscompares++;
         $display("FAIL mem_run: got busy=%b cyc=%0d, required 1 7", busy_w[0], cyc_w[0]);
      end
      #2 reset = 1'b1;
      #1;
      for (int k = 0; k < 4; k++) begin
         vectors++;
         if ({busy_w[k], done_w[k], to_w[k], halted_w[k], cyc_w[k], hcyc_w[k], rd_w[k], wr_w[k]} !== '0) begin
            miscompares++;
            $display("FAIL async_reset[%0d]: got busy=%b cyc=%0d rd=%h, required all zero", k, busy_w[k], cyc_w[k], rd_w[k]);
         end
      end
      #1 reset = 1'b0;
      tick(); tick();
      vectors++;
      if (busy_w[0] !== 1'b0 || done_w[0] !== 1'b0 || cyc_w[0] !== 32'd0) begin
         miscompares++;
         $display("FAIL reset_waits: got busy=%b done=%b cyc=%0d, required 0 0 0", busy_w[0], done_w[0], cyc_w[0]);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 500; c++) begin
         start = ($urandom_range(0, 5) == 0);
         for (int n = 0; n < 4; n++) set_inst(n, ($urandom_range(0, 9) < 7) ? 32'h0 : nz());
         mem_en = 4'($urandom); mem_wr_en = 4'($urandom);
         if ($urandom_range(0, 99) == 0) begin
            reset = 1'b1;
            #2 reset = 1'b0;
         end
         tick();
         for (int k = 0; k < 4; k++) begin
            vectors++;
            if (busy_w[k] !== (m_phase[k] == 1 || m_phase[k] == 2) || done_w[k] !== (m_phase[k] == 3) ||
                to_w[k] !== m_to[k] || halted_w[k] !== m_halt[k] || cyc_w[k] !== m_cyc[k]) begin
               miscompares++;
               $display("FAIL rand_ctrl[%0d] c=%0d: got busy=%b done=%b to=%b halted=%h cyc=%0d, required phase=%0d to=%b halted=%h cyc=%0d",
                        k, c, busy_w[k], done_w[k], to_w[k], halted_w[k], cyc_w[k], m_phase[k], m_to[k], m_halt[k], m_cyc[k]);
            end
            for (int n = 0; n < 4; n++) begin
               vectors++;
               if (hcyc_w[k][n*32 +: 32] !== m_hcyc[k][n] || rd_w[k][n*32 +: 32] !== m_rd[k][n] ||
                   wr_w[k][n*32 +: 32] !== m_wr[k][n]) begin
                  miscompares++;
                  $display("FAIL rand_node[%0d][%0d] c=%0d: got hcyc=%0d rd=%0d wr=%0d, required %0d %0d %0d",
                           k, n, c, hcyc_w[k][n*32 +: 32], rd_w[k][n*32 +: 32], wr_w[k][n*32 +: 32],
                           m_hcyc[k][n], m_rd[k][n], m_wr[k][n]);
               end
            end
         end
      end
      start = 1'b0;
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      test_reset();
      test_all_halt();
      test_sticky_and_simult();
      test_halt_hold();
      test_timeout();
      test_restart_clears();
      test_mem_counts_and_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
